// File: rtl/mcpu_ram_arbiter_if.sv
// Bus bundle between the two CPU ports, the arbiter and the
// single-port RAM controller.
interface mcpu_ram_arbiter_if #(
   parameter int WORD_SIZE  = 16,
   parameter int ADDR_WIDTH = 8
);
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic                  i_ack;
   logic [WORD_SIZE-1:0]  i_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [WORD_SIZE-1:0]  d_wdata;
   logic                  d_ack;
   logic [WORD_SIZE-1:0]  d_rdata;

   logic                  ram_we;
   logic                  ram_re;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [WORD_SIZE-1:0]  ram_wdata;
   logic [WORD_SIZE-1:0]  ram_rdata;

   logic                  busy;

   modport slave (
      input  i_req, i_addr,
      input  d_req, d_we, d_addr, d_wdata,
      input  ram_rdata,
      output i_ack, i_rdata,
      output d_ack, d_rdata,
      output ram_we, ram_re, ram_addr, ram_wdata,
      output busy
   );

   modport master (
      output i_req, i_addr,
      output d_req, d_we, d_addr, d_wdata,
      output ram_rdata,
      input  i_ack, i_rdata,
      input  d_ack, d_rdata,
      input  ram_we, ram_re, ram_addr, ram_wdata,
      input  busy
   );
endinterface

// File: rtl/mcpu_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the
// instruction-fetch port and the data port; 3 cycles per access.
module mcpu_ram_arbiter #(
   parameter int WORD_SIZE  = 16,
   parameter int ADDR_WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   mcpu_ram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_t;

   state_t state;
   owner_t owner;
   owner_t last_owner;
   logic   grant_d;

   // On a tie the port that did not win last time gets the grant.
   assign grant_d = bus.d_req &&
                    (!bus.i_req || last_owner == OWN_I);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         owner         <= OWN_I;
         last_owner    <= OWN_I;
         bus.ram_we    <= 1'b0;
         bus.ram_re    <= 1'b0;
         bus.ram_addr  <= {ADDR_WIDTH{1'b0}};
         bus.ram_wdata <= {WORD_SIZE{1'b0}};
         bus.i_ack     <= 1'b0;
         bus.d_ack     <= 1'b0;
         bus.i_rdata   <= {WORD_SIZE{1'b0}};
         bus.d_rdata   <= {WORD_SIZE{1'b0}};
         bus.busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.i_req || bus.d_req) begin
                  owner      <= grant_d ? OWN_D : OWN_I;
                  last_owner <= grant_d ? OWN_D : OWN_I;
                  if (grant_d) begin
                     bus.ram_addr  <= bus.d_addr;
                     bus.ram_wdata <= bus.d_wdata;
                  end else begin
                     bus.ram_addr  <= bus.i_addr;
                  end
                  bus.ram_we <= grant_d && bus.d_we;
                  bus.ram_re <= !(grant_d && bus.d_we);
                  bus.busy   <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               bus.ram_we <= 1'b0;
               bus.ram_re <= 1'b0;
               if (owner == OWN_D) begin
                  bus.d_ack <= 1'b1;
                  if (bus.ram_re)
                     bus.d_rdata <= bus.ram_rdata;
               end else begin
                  bus.i_ack <= 1'b1;
                  if (bus.ram_re)
                     bus.i_rdata <= bus.ram_rdata;
               end
               state <= RESP;
            end
            RESP: begin
               bus.i_ack <= 1'b0;
               bus.d_ack <= 1'b0;
               bus.busy  <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mcpu_ram_arbiter.sv
// Directed bench for mcpu_ram_arbiter with a behavioural RAM
// and a scoreboard copy of its contents.
module tb_mcpu_ram_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   logic [15:0] mem [256];
   logic [15:0] sb  [256];

   mcpu_ram_arbiter_if #(
      .WORD_SIZE(16),
      .ADDR_WIDTH(8)
   ) bus ();

   mcpu_ram_arbiter #(
      .WORD_SIZE(16),
      .ADDR_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.ram_rdata = bus.ram_re ? mem[bus.ram_addr] : 16'h0;

   always @(posedge clk)
      if (bus.ram_we)
         mem[bus.ram_addr] <= bus.ram_wdata;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {3'b0, bus.i_ack, bus.d_ack,
              bus.i_rdata, bus.d_rdata,
              bus.ram_we, bus.ram_re, bus.ram_addr,
              bus.ram_wdata, bus.busy};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_outs", outs(), 64'h0);
      tick();
      tick();
      chk("rst_hold", outs(), 64'h0);
      rst_n = 1'b1;
   endtask

   // Issues one access from IDLE and returns to IDLE.
   task automatic access(input bit port_d,
                         input bit we,
                         input logic [7:0] addr,
                         input logic [15:0] wdata,
                         output logic [15:0] rd);
      int cnt;
      if (port_d) begin
         bus.d_req   = 1'b1;
         bus.d_we    = we;
         bus.d_addr  = addr;
         bus.d_wdata = wdata;
      end else begin
         bus.i_req  = 1'b1;
         bus.i_addr = addr;
      end
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (!(bus.i_ack || bus.d_ack) && cnt < 8);
      chk("acc_lat", 64'(cnt), 64'd2);
      chk("acc_own", {62'b0, bus.d_ack, bus.i_ack},
          port_d ? 64'd2 : 64'd1);
      rd = port_d ? bus.d_rdata : bus.i_rdata;
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      tick();
   endtask

   initial begin
      logic [15:0] rd;
      logic [15:0] w;
      logic [7:0]  da;
      logic [7:0]  ia;
      bit          exp_d;
      int          cnt;

      bus.i_req   = 1'b0;
      bus.i_addr  = 8'h0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = 8'h0;
      bus.d_wdata = 16'h0;

      tick();
      do_reset();

      // single data write
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 8'h10;
      bus.d_wdata = 16'hBEEF;
      tick();
      chk("wr_issue",
          {bus.ram_we, bus.ram_re, bus.busy, bus.d_ack},
          4'b1010);
      chk("wr_addr", bus.ram_addr, 8'h10);
      chk("wr_wdata", bus.ram_wdata, 16'hBEEF);
      tick();
      chk("wr_resp",
          {bus.ram_we, bus.ram_re, bus.busy, bus.d_ack},
          4'b0011);
      bus.d_req = 1'b0;
      tick();
      chk("wr_idle", {bus.busy, bus.d_ack}, 2'b00);
      sb[8'h10] = 16'hBEEF;

      // fetch of the word just written
      bus.i_req  = 1'b1;
      bus.i_addr = 8'h10;
      tick();
      chk("fe_issue", {bus.ram_we, bus.ram_re}, 2'b01);
      chk("fe_addr", bus.ram_addr, 8'h10);
      tick();
      chk("fe_ack", {bus.i_ack, bus.d_ack}, 2'b10);
      chk("fe_rdata", bus.i_rdata, 16'hBEEF);
      chk("fe_drd", bus.d_rdata, 16'h0);
      bus.i_req = 1'b0;
      tick();

      // fill the whole RAM through the data port
      for (int a = 0; a < 256; a++) begin
         w = 16'($urandom);
         access(1'b1, 1'b1, 8'(a), w, rd);
         sb[a] = w;
      end
      chk("wr_keep_drd", bus.d_rdata, 16'h0);

      // simultaneous requests right after reset
      tick();
      do_reset();
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 8'h20;
      bus.i_req  = 1'b1;
      bus.i_addr = 8'h21;
      tick();
      chk("tie_c2", {bus.ram_re, bus.ram_addr}, {1'b1, 8'h20});
      tick();
      chk("tie_c3", {bus.d_ack, bus.i_ack}, 2'b10);
      chk("tie_drd", bus.d_rdata, sb[8'h20]);
      bus.d_req = 1'b0;
      tick();
      chk("tie_c4", {bus.d_ack, bus.i_ack, bus.busy}, 3'b000);
      tick();
      chk("tie_c5", {bus.ram_re, bus.ram_addr}, {1'b1, 8'h21});
      tick();
      chk("tie_c6", {bus.d_ack, bus.i_ack}, 2'b01);
      chk("tie_ird", bus.i_rdata, sb[8'h21]);
      bus.i_req = 1'b0;
      tick();

      // sustained contention: strict alternation, D first
      da = 8'h03;
      ia = 8'hF0;
      exp_d = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = da;
      bus.i_addr = ia;
      bus.d_req  = 1'b1;
      bus.i_req  = 1'b1;
      for (int n = 0; n < 256; n++) begin
         cnt = 0;
         do begin
            tick();
            cnt++;
         end while (!(bus.i_ack || bus.d_ack) && cnt < 8);
         chk("cont_gap", 64'(cnt), (n == 0) ? 64'd2 : 64'd3);
         chk("cont_own", {62'b0, bus.d_ack, bus.i_ack},
             exp_d ? 64'd2 : 64'd1);
         if (exp_d) begin
            chk("cont_drd", bus.d_rdata, sb[da]);
            da = da + 8'd7;
            bus.d_addr = da;
         end else begin
            chk("cont_ird", bus.i_rdata, sb[ia]);
            ia = ia + 8'd13;
            bus.i_addr = ia;
         end
         exp_d = !exp_d;
      end
      bus.d_req = 1'b0;
      bus.i_req = 1'b0;
      tick();

      // reset in the middle of a fetch
      bus.i_req  = 1'b1;
      bus.i_addr = 8'h05;
      tick();
      chk("mid_issue", bus.ram_re, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_async", outs(), 64'h0);
      tick();
      chk("mid_noack", outs(), 64'h0);
      rst_n = 1'b1;
      access(1'b0, 1'b0, 8'h05, 16'h0, rd);
      chk("mid_refetch", rd, sb[8'h05]);

      // sweep reads through both ports
      for (int a = 0; a < 256; a++) begin
         access(1'b0, 1'b0, 8'(a), 16'h0, rd);
         chk("sw_ird", rd, sb[a]);
      end
      for (int a = 0; a < 256; a++) begin
         access(1'b1, 1'b0, 8'(a), 16'h0, rd);
         chk("sw_drd", rd, sb[a]);
      end

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end
endmodule

// File: doc/mcpu_ram_arbiter.md
MCPU_RAM_ARBITER -- requirements
Module: mcpu_ram_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, RAM data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8, RAM address width; RAM depth 1<<ADDR_WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_req  input  1  instruction-fetch read request, held until i_ack.
REQ-006 i_addr  input  ADDR_WIDTH  fetch address.
REQ-007 i_ack  output  1  one-cycle completion pulse for fetch.
REQ-008 i_rdata  output  WORD_SIZE  fetched word, valid when i_ack=1, held until the next i_ack.
REQ-009 d_req  input  1  data-port request, held until d_ack.
REQ-010 d_we  input  1  1=write, 0=read.
REQ-011 d_addr  input  ADDR_WIDTH  data address.
REQ-012 d_wdata  input  WORD_SIZE  write data.
REQ-013 d_ack  output  1  one-cycle completion pulse for data access.
REQ-014 d_rdata  output  WORD_SIZE  read word, valid when d_ack=1 after a read, held until the next data-read ack.
REQ-015 ram_we, ram_re  output  1 each  strobes to the single-port RAM controller.
REQ-016 ram_addr  output  ADDR_WIDTH; ram_wdata  output  WORD_SIZE; ram_rdata  input  WORD_SIZE (combinational read of ram_addr while ram_re=1).
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states IDLE, ISSUE, RESP; every access takes exactly 3 cycles: IDLE -> ISSUE -> RESP -> IDLE.
REQ-019 IDLE: if neither request is high, remain in IDLE; otherwise latch owner, address, we (0 for fetch) and wdata, and go to ISSUE.
REQ-020 Arbitration on simultaneous i_req and d_req: round-robin; grant goes to the port not recorded in last_owner; last_owner updates on every grant.
REQ-021 A single requester is granted immediately regardless of last_owner.
REQ-022 ISSUE: ram_addr/ram_wdata drive the latched values; ram_re=1 for reads, ram_we=1 for writes, never both; ram_rdata is sampled at the ISSUE->RESP edge.
REQ-023 ram_we/ram_re are 0 in IDLE and RESP; ram_addr/ram_wdata hold their last values outside ISSUE.
REQ-024 RESP: the owner's ack=1 for that cycle only, the other ack=0; a read updates the owner's rdata register from the sampled word; a write leaves d_rdata unchanged.
REQ-025 Requesters drop req at the edge ending the ack cycle; req still high in the following IDLE is a new request.
REQ-026 Inputs changing during ISSUE/RESP do not affect the access in flight.
REQ-027 i_ack and d_ack are never high in the same cycle.
REQ-028 With both ports continuously requesting, grants alternate, so no port waits more than one access (max 6 cycles from request to ack start).

Reset
REQ-029 rst_n=0 asynchronously forces: state IDLE, last_owner=I (so the first tie goes to D), ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, busy=0.
REQ-030 Reset during ISSUE/RESP aborts the access with no ack; a write cut mid-ISSUE has undefined RAM effect; after release the requester re-issues.
REQ-031 First arbitration occurs at the first rising edge with rst_n=1.

Verification
REQ-032 Write D: d_req=1, d_we=1, d_addr=8'h10, d_wdata=16'hBEEF -> ram_we=1 with ram_addr=8'h10 one cycle later, d_ack the cycle after, busy high 2 cycles.
REQ-033 Fetch after write: i_req=1, i_addr=8'h10 -> ram_re=1 in ISSUE, i_ack with i_rdata=16'hBEEF; d_rdata unchanged.
REQ-034 Tie after reset: i_req and d_req rise together (d_we=0, d_addr=8'h20; i_addr=8'h21) -> D served first, d_ack at cycle 3, then I, i_ack at cycle 6; acks never overlap.
REQ-035 Sustained contention: both requests re-asserted immediately after each ack for 256 accesses -> strict D/I alternation, every ack within 6 cycles of its request.
REQ-036 Reset mid-access: rst_n=0 during ISSUE of a read -> ram_re falls with no clock, no ack issued, all outputs zero; after release a pending i_req is served normally.
REQ-037 Full sweep: write $random to all 256 addresses via D, then fetch all via I and read all via D -> every returned word matches the scoreboard copy.
